// File: rtl/axi_protocol_monitor.sv
// Passive AXI link checker. It watches AW/W/B/AR/R and flags handshake-stability, 4KB-crossing,
// WLAST/beat-count and outstanding-count violations through pulse, sticky, first-error and count outputs.
module axi_protocol_monitor #(
    parameter int ID_WIDTH        = 4,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 32,
    parameter int LEN_WIDTH       = 8,
    parameter int SIZE_WIDTH      = 3,
    parameter int BURST_WIDTH     = 2,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [10:0]             chk_en,
    input  logic                    clr,
    input  logic [ID_WIDTH-1:0]     awid,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic [LEN_WIDTH-1:0]    awlen,
    input  logic [SIZE_WIDTH-1:0]   awsize,
    input  logic [BURST_WIDTH-1:0]  awburst,
    input  logic                    awvalid,
    input  logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wlast,
    input  logic                    wvalid,
    input  logic                    wready,
    input  logic [ID_WIDTH-1:0]     bid,
    input  logic [1:0]              bresp,
    input  logic                    bvalid,
    input  logic                    bready,
    input  logic [ID_WIDTH-1:0]     arid,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic [LEN_WIDTH-1:0]    arlen,
    input  logic [SIZE_WIDTH-1:0]   arsize,
    input  logic [BURST_WIDTH-1:0]  arburst,
    input  logic                    arvalid,
    input  logic                    arready,
    input  logic [ID_WIDTH-1:0]     rid,
    input  logic [DATA_WIDTH-1:0]   rdata,
    input  logic [1:0]              rresp,
    input  logic                    rlast,
    input  logic                    rvalid,
    input  logic                    rready,
    output logic [10:0]             err_pulse,
    output logic [10:0]             err_status,
    output logic [3:0]              first_err,
    output logic                    first_vld,
    output logic [CNT_WIDTH-1:0]    err_count
);

    localparam int PTR_W  = $clog2(MAX_OUTSTANDING);
    localparam int OUT_W  = PTR_W + 1;
    localparam int DONE_W = OUT_W + 2;
    localparam int BEAT_W = LEN_WIDTH + 1;
    localparam int AX_W   = ID_WIDTH + ADDR_WIDTH + LEN_WIDTH + SIZE_WIDTH + BURST_WIDTH;
    localparam int WP_W   = DATA_WIDTH + DATA_WIDTH / 8 + 1;
    localparam logic [BURST_WIDTH-1:0] BURST_INCR = BURST_WIDTH'(1);
    localparam logic [OUT_W-1:0]       OUT_MAX    = OUT_W'(MAX_OUTSTANDING);

    logic unused_bus;
    assign unused_bus = ^{bid, bresp, rid, rdata, rresp};

    logic aw_hs, w_hs, wlast_hs, b_hs, ar_hs, r_hs, rlast_hs;
    assign aw_hs    = awvalid & awready;
    assign w_hs     = wvalid & wready;
    assign wlast_hs = w_hs & wlast;
    assign b_hs     = bvalid & bready;
    assign ar_hs    = arvalid & arready;
    assign r_hs     = rvalid & rready;
    assign rlast_hs = r_hs & rlast;

    // Stability: payload captured at the end of any stalled cycle, compared in the next one
    logic [AX_W-1:0] ar_pay, ar_pay_q, aw_pay, aw_pay_q;
    logic [WP_W-1:0] w_pay, w_pay_q;
    logic            ar_pend_q, aw_pend_q, w_pend_q;
    assign ar_pay = {arid, araddr, arlen, arsize, arburst};
    assign aw_pay = {awid, awaddr, awlen, awsize, awburst};
    assign w_pay  = {wdata, wstrb, wlast};

    logic err_ar_stab, err_aw_stab, err_w_stab;
    assign err_ar_stab = ar_pend_q & (~arvalid | (ar_pay != ar_pay_q));
    assign err_aw_stab = aw_pend_q & (~awvalid | (aw_pay != aw_pay_q));
    assign err_w_stab  = w_pend_q  & (~wvalid  | (w_pay  != w_pay_q));

    function automatic logic crosses_4k(input logic [ADDR_WIDTH-1:0] addr,
                                        input logic [LEN_WIDTH-1:0]  len,
                                        input logic [SIZE_WIDTH-1:0] size);
        logic [ADDR_WIDTH:0] bytes;
        logic [ADDR_WIDTH:0] last;
        bytes = {{(ADDR_WIDTH + 1 - LEN_WIDTH){1'b0}}, len} + {{ADDR_WIDTH{1'b0}}, 1'b1};
        bytes = bytes << size;
        last  = {1'b0, addr} + bytes - {{ADDR_WIDTH{1'b0}}, 1'b1};
        return last[ADDR_WIDTH:12] != {1'b0, addr[ADDR_WIDTH-1:12]};
    endfunction

    logic err_ar_4k, err_aw_4k;
    assign err_ar_4k = ar_hs & (arburst == BURST_INCR) & crosses_4k(araddr, arlen, arsize);
    assign err_aw_4k = aw_hs & (awburst == BURST_INCR) & crosses_4k(awaddr, awlen, awsize);

    // AW length FIFO and W beat tracking
    logic [LEN_WIDTH-1:0] fifo_q [MAX_OUTSTANDING];
    logic [PTR_W-1:0]     rd_ptr_q, wr_ptr_q;
    logic [OUT_W-1:0]     fifo_cnt_q;
    logic [BEAT_W-1:0]    beat_cnt_q;
    logic                 fifo_empty, fifo_full, have_head, do_push, do_pop;
    logic [LEN_WIDTH-1:0] head_len;
    logic [BEAT_W:0]      beat_nxt, head_nxt;

    assign fifo_empty = (fifo_cnt_q == '0);
    assign fifo_full  = (fifo_cnt_q == OUT_MAX);
    // An AW arriving into an empty FIFO is visible to a W in the same cycle
    assign have_head  = ~fifo_empty | aw_hs;
    assign head_len   = fifo_empty ? awlen : fifo_q[rd_ptr_q];
    assign beat_nxt   = {1'b0, beat_cnt_q} + {{BEAT_W{1'b0}}, 1'b1};
    assign head_nxt   = {2'b00, head_len} + {{BEAT_W{1'b0}}, 1'b1};
    assign do_push    = aw_hs & ~fifo_full & ~(wlast_hs & fifo_empty);
    assign do_pop     = wlast_hs & ~fifo_empty;

    logic err_wlast_early, err_wlast_late, err_aw_ovf;
    assign err_wlast_early = wlast_hs & have_head & (beat_nxt < head_nxt);
    assign err_wlast_late  = w_hs & ((have_head & ~wlast & (beat_nxt == head_nxt)) |
                                     (wlast & ~have_head));
    assign err_aw_ovf      = aw_hs & fifo_full;

    // Completed-write and outstanding-read counters
    logic [DONE_W-1:0] wr_done_q;
    logic [OUT_W-1:0]  rd_out_q;
    logic              done_inc, done_dec, rd_inc, rd_dec;
    logic err_b, err_r, err_ar_ovf;
    assign done_inc   = wlast_hs & ~(&wr_done_q);
    assign done_dec   = b_hs & ((wr_done_q != '0) | wlast_hs);
    assign err_b      = b_hs & (wr_done_q == '0) & ~wlast_hs;
    assign err_r      = r_hs & (rd_out_q == '0);
    assign err_ar_ovf = ar_hs & (rd_out_q == OUT_MAX);
    assign rd_inc     = ar_hs & ~(rd_out_q == OUT_MAX);
    assign rd_dec     = rlast_hs & (rd_out_q != '0);

    logic [10:0] pulse_d, status_d;
    logic [3:0]  first_d;
    logic        first_vld_d;
    logic [CNT_WIDTH-1:0] count_d;
    logic [3:0]  low_idx;
    logic [10:0] err_pulse_q, err_status_q;
    logic [3:0]  first_err_q;
    logic        first_vld_q;
    logic [CNT_WIDTH-1:0] err_count_q;

    assign pulse_d = {err_ar_ovf, err_aw_ovf, err_r, err_b, err_wlast_late, err_wlast_early,
                      err_aw_4k, err_ar_4k, err_w_stab, err_aw_stab, err_ar_stab} & chk_en;

    always_comb begin
        low_idx = '0;
        for (int i = 10; i >= 0; i--) begin
            if (pulse_d[i]) low_idx = 4'(i);
        end
        status_d    = err_status_q | pulse_d;
        first_d     = first_err_q;
        first_vld_d = first_vld_q;
        count_d     = err_count_q;
        if (clr) begin
            status_d    = pulse_d;
            first_d     = (|pulse_d) ? low_idx : 4'd0;
            first_vld_d = |pulse_d;
            count_d     = (|pulse_d) ? {{(CNT_WIDTH-1){1'b0}}, 1'b1} : '0;
        end else begin
            if (!first_vld_q && (|pulse_d)) begin
                first_d     = low_idx;
                first_vld_d = 1'b1;
            end
            if ((|pulse_d) && !(&err_count_q)) count_d = err_count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ar_pend_q    <= 1'b0;
            aw_pend_q    <= 1'b0;
            w_pend_q     <= 1'b0;
            ar_pay_q     <= '0;
            aw_pay_q     <= '0;
            w_pay_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            fifo_cnt_q   <= '0;
            beat_cnt_q   <= '0;
            wr_done_q    <= '0;
            rd_out_q     <= '0;
            err_pulse_q  <= '0;
            err_status_q <= '0;
            first_err_q  <= '0;
            first_vld_q  <= 1'b0;
            err_count_q  <= '0;
        end else begin
            ar_pend_q <= arvalid & ~arready;
            aw_pend_q <= awvalid & ~awready;
            w_pend_q  <= wvalid & ~wready;
            if (arvalid && !arready) ar_pay_q <= ar_pay;
            if (awvalid && !awready) aw_pay_q <= aw_pay;
            if (wvalid && !wready)   w_pay_q  <= w_pay;

            if (do_push) begin
                fifo_q[wr_ptr_q] <= awlen;
                wr_ptr_q         <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      fifo_cnt_q <= fifo_cnt_q + 1'b1;
            else if (do_pop && !do_push) fifo_cnt_q <= fifo_cnt_q - 1'b1;

            if (wlast_hs)                  beat_cnt_q <= '0;
            else if (w_hs && !(&beat_cnt_q)) beat_cnt_q <= beat_cnt_q + 1'b1;

            if (done_inc && !done_dec)      wr_done_q <= wr_done_q + 1'b1;
            else if (done_dec && !wlast_hs) wr_done_q <= wr_done_q - 1'b1;

            if (rd_inc && !rd_dec)      rd_out_q <= rd_out_q + 1'b1;
            else if (rd_dec && !rd_inc) rd_out_q <= rd_out_q - 1'b1;

            err_pulse_q  <= pulse_d;
            err_status_q <= status_d;
            first_err_q  <= first_d;
            first_vld_q  <= first_vld_d;
            err_count_q  <= count_d;
        end
    end

    assign err_pulse  = err_pulse_q;
    assign err_status = err_status_q;
    assign first_err  = first_err_q;
    assign first_vld  = first_vld_q;
    assign err_count  = err_count_q;

endmodule
